// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the memory arbiter slice.
package mem_arb_pkg;

  localparam int unsigned DEF_NUM_REQ  = 4;
  localparam int unsigned DEF_DEPTH    = 8;
  localparam int unsigned DEF_BIT_SIZE = 16;

  // Upper bound on requesters; sizes the one-hot decode helper.
  localparam int unsigned MAX_REQ     = 8;
  localparam int unsigned MAX_IDX_W   = 3;

  // Index width for n requesters, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned REQ_IDX_W = idx_w(DEF_NUM_REQ);

  // One-hot to binary index; the input must have at most one bit set.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

  // Increment modulo n with an explicit wrap, valid for any n.
  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle of the memory arbiter.
//   slave  : arbiter view (takes requests and memory read data, drives grants,
//            responses and memory control).
//   master : requester/memory environment view (the mirror image).
// Parameters must match the ones of the attached mem_arbiter.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned BIT_SIZE = DEF_BIT_SIZE
);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_write;
  logic [NUM_REQ*DEPTH-1:0]    req_addr;
  logic [NUM_REQ*BIT_SIZE-1:0] req_wdata;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0]          rsp_valid;
  logic [BIT_SIZE-1:0]         rsp_data;
  logic                        mem_write_enable;
  logic [DEPTH-1:0]            mem_write_addr;
  logic [BIT_SIZE-1:0]         mem_data_in;
  logic [DEPTH-1:0]            mem_read_addr;
  logic [BIT_SIZE-1:0]         mem_data_out;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_data_out,
    output req_ready, rsp_valid, rsp_data,
    output mem_write_enable, mem_write_addr, mem_data_in, mem_read_addr
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_data_out,
    input  req_ready, rsp_valid, rsp_data,
    input  mem_write_enable, mem_write_addr, mem_data_in, mem_read_addr
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from its pointer with wrap at N-1,
// first requester found wins; pointer moves past the winner on a grant.
//   clk, rst_n  : clock, async active-low reset (pointer returns to 0)
//   req         : request vector
//   grant       : one-hot grant (combinational)
//   grant_idx   : binary index of the winner (combinational)
//   grant_valid : any grant this cycle (combinational)
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N = DEF_NUM_REQ
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req,
  output logic [N-1:0]        grant,
  output logic [idx_w(N)-1:0] grant_idx,
  output logic                grant_valid
);

  localparam int unsigned IW = idx_w(N);

  logic [IW-1:0] ptr;
  int unsigned   cand;

  // Rotating priority search starting at ptr.
  always_comb begin
    grant = '0;
    cand  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if ((grant == '0) && req[cand[IW-1:0]]) grant[cand[IW-1:0]] = 1'b1;
    end
  end

  assign grant_valid = |grant;
  assign grant_idx   = IW'(onehot_to_idx(MAX_REQ'(grant)));

  // Pointer register; holds when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= IW'(next_ptr(32'(grant_idx), N));
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one dual-port memory (async read, sync write) between NUM_REQ
// requesters with independent round-robin arbitration per port.
//   clk, rst_n : clock, async active-low reset
//   bus        : mem_arbiter_if.slave -- requests/grants, one-cycle registered
//                read responses, and the memory read/write port signals
// Grants and memory controls are combinational and forced low in reset.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned BIT_SIZE = DEF_BIT_SIZE
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned IW = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]  rd_cand, wr_cand;
  logic [NUM_REQ-1:0]  rd_grant, wr_grant;
  logic [IW-1:0]       rd_idx, wr_idx;
  logic                rd_gv, wr_gv;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [BIT_SIZE-1:0] rsp_data_q;

  // Reset gating on the candidates keeps grants and write enable low in reset.
  assign rd_cand = bus.req_valid & ~bus.req_write & {NUM_REQ{rst_n}};
  assign wr_cand = bus.req_valid &  bus.req_write & {NUM_REQ{rst_n}};

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (rd_cand),
    .grant       (rd_grant),
    .grant_idx   (rd_idx),
    .grant_valid (rd_gv)
  );

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (wr_cand),
    .grant       (wr_grant),
    .grant_idx   (wr_idx),
    .grant_valid (wr_gv)
  );

  assign bus.req_ready = rd_grant | wr_grant;

  // Operand muxing onto the memory ports; idle ports drive zero.
  assign bus.mem_write_enable = wr_gv;
  assign bus.mem_write_addr   = wr_gv ? bus.req_addr[32'(wr_idx)*DEPTH +: DEPTH]       : '0;
  assign bus.mem_data_in      = wr_gv ? bus.req_wdata[32'(wr_idx)*BIT_SIZE +: BIT_SIZE] : '0;
  assign bus.mem_read_addr    = rd_gv ? bus.req_addr[32'(rd_idx)*DEPTH +: DEPTH]       : '0;

  // Response register: strobe for one cycle, data holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rd_grant;
      if (rd_gv) rsp_data_q <= bus.mem_data_out;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  typedef struct packed {
    logic [NR-1:0] oh;
    logic [DW-1:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if #(.NUM_REQ(NR), .DEPTH(AW), .BIT_SIZE(DW)) bus ();
  mem_arbiter_if #(.NUM_REQ(3),  .DEPTH(AW), .BIT_SIZE(DW)) bus3 ();

  mem_arbiter #(.NUM_REQ(NR), .DEPTH(AW), .BIT_SIZE(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Three-requester instance, all requesters reading continuously.
  mem_arbiter #(.NUM_REQ(3), .DEPTH(AW), .BIT_SIZE(DW)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );
  assign bus3.req_valid    = 3'b111;
  assign bus3.req_write    = 3'b000;
  assign bus3.req_addr     = '0;
  assign bus3.req_wdata    = '0;
  assign bus3.mem_data_out = '0;

  // Environment memory: async read, sync write, with a preload port.
  logic [DW-1:0] mem [256];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.mem_write_enable) mem[bus.mem_write_addr] <= bus.mem_data_in;
  end
  assign bus.mem_data_out = mem[bus.mem_read_addr];

  logic [DW-1:0] ref_mem [256];
  rsp_t          sb [$];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i]           = 1'b1;
    bus.req_write[i]           = w;
    bus.req_addr[i*AW +: AW]   = a;
    bus.req_wdata[i*DW +: DW]  = d;
  endtask

  // One cycle: check grants, queue the expected response, clock, compare.
  task automatic step(input string tag, input logic [NR-1:0] exp_ready,
                      input logic [NR-1:0] exp_oh, input logic [DW-1:0] exp_data);
    rsp_t r;
    #1;
    chk({tag, "/ready"}, 32'(bus.req_ready), 32'(exp_ready));
    sb.push_back('{oh: exp_oh, data: exp_data});
    @(posedge clk);
    #1;
    r = sb.pop_front();
    chk({tag, "/rsp_valid"}, 32'(bus.rsp_valid), 32'(r.oh));
    if (r.oh != '0) chk({tag, "/rsp_data"}, 32'(bus.rsp_data), 32'(r.data));
  endtask

  initial begin
    logic [DW-1:0] v;
    rst_n   = 1'b0;
    pl_en   = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    clear_reqs();

    // Preload memory during reset.
    pl_en = 1'b1;
    for (int a = 0; a < 256; a++) begin
      v = (a == 5) ? 16'h1234 : (a == 'h20) ? 16'h5555 : (16'(a * 257) ^ 16'h3C3C);
      pl_addr    = AW'(a);
      pl_data    = v;
      ref_mem[a] = v;
      @(posedge clk);
      #1;
    end
    pl_en = 1'b0;

    // Reset state with requests pending.
    set_req(0, 1'b1, 8'h50, 16'hFFFF);
    set_req(1, 1'b0, 8'h05, 16'h0);
    #1;
    chk("rst/ready",    32'(bus.req_ready),        32'h0);
    chk("rst/we",       32'(bus.mem_write_enable), 32'h0);
    chk("rst/rsp_v",    32'(bus.rsp_valid),        32'h0);
    chk("rst/rsp_d",    32'(bus.rsp_data),         32'h0);
    chk("rst/ready3",   32'(bus3.req_ready),       32'h0);
    clear_reqs();
    rst_n = 1'b1;

    // Round robin from reset: 4 requesters and the 3-requester instance.
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, AW'(8'h40 + i), '0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("rr3/ready", 32'(bus3.req_ready), 32'(1 << (c % 3)));
      step("rr", NR'(1 << (c % 4)), NR'(1 << (c % 4)), ref_mem[8'h40 + (c % 4)]);
    end

    // Idle cycle: no grants, ports driven to zero.
    clear_reqs();
    #1;
    chk("idle/waddr", 32'(bus.mem_write_addr), 32'h0);
    chk("idle/wdata", 32'(bus.mem_data_in),    32'h0);
    chk("idle/raddr", 32'(bus.mem_read_addr),  32'h0);
    step("idle", 4'b0000, 4'b0000, '0);

    // Single read of the preloaded word.
    set_req(0, 1'b0, 8'h05, '0);
    step("single", 4'b0001, 4'b0001, 16'h1234);

    // Pointer holds across idle cycles.
    clear_reqs();
    set_req(1, 1'b0, 8'h41, '0);
    step("hold_a", 4'b0010, 4'b0010, ref_mem[8'h41]);
    clear_reqs();
    for (int k = 0; k < 3; k++) step("hold_idle", 4'b0000, 4'b0000, '0);
    set_req(0, 1'b0, 8'h44, '0);
    set_req(2, 1'b0, 8'h46, '0);
    step("hold_b", 4'b0100, 4'b0100, ref_mem[8'h46]);
    bus.req_valid[2] = 1'b0;
    step("hold_c", 4'b0001, 4'b0001, ref_mem[8'h44]);

    // Write then read back from the same requester.
    clear_reqs();
    set_req(2, 1'b1, 8'h10, 16'hBEEF);
    #1;
    chk("wr/we",    32'(bus.mem_write_enable), 32'h1);
    chk("wr/waddr", 32'(bus.mem_write_addr),   32'h10);
    chk("wr/wdata", 32'(bus.mem_data_in),      32'hBEEF);
    step("wr", 4'b0100, 4'b0000, '0);
    ref_mem[8'h10] = 16'hBEEF;
    clear_reqs();
    set_req(2, 1'b0, 8'h10, '0);
    step("rd_after_wr", 4'b0100, 4'b0100, 16'hBEEF);

    // Same-cycle read and write to one address: read sees old data.
    clear_reqs();
    set_req(1, 1'b1, 8'h20, 16'hAAAA);
    set_req(3, 1'b0, 8'h20, '0);
    #1;
    chk("col/raddr", 32'(bus.mem_read_addr),  32'h20);
    chk("col/waddr", 32'(bus.mem_write_addr), 32'h20);
    step("collide", 4'b1010, 4'b1000, ref_mem[8'h20]);
    ref_mem[8'h20] = 16'hAAAA;
    clear_reqs();
    set_req(3, 1'b0, 8'h20, '0);
    step("rd_new", 4'b1000, 4'b1000, 16'hAAAA);

    // Write arbiter round robin (pointer now at 2: requester 3 before 0).
    clear_reqs();
    set_req(0, 1'b1, 8'h30, 16'h1111);
    set_req(3, 1'b1, 8'h31, 16'h3333);
    #1;
    chk("wrr/waddr", 32'(bus.mem_write_addr), 32'h31);
    step("wrr_a", 4'b1000, 4'b0000, '0);
    ref_mem[8'h31] = 16'h3333;
    bus.req_valid[3] = 1'b0;
    step("wrr_b", 4'b0001, 4'b0000, '0);
    ref_mem[8'h30] = 16'h1111;
    clear_reqs();
    set_req(0, 1'b0, 8'h30, '0);
    set_req(1, 1'b0, 8'h31, '0);
    step("rb0", 4'b0001, 4'b0001, ref_mem[8'h30]);
    bus.req_valid[0] = 1'b0;
    step("rb1", 4'b0010, 4'b0010, ref_mem[8'h31]);

    // Asynchronous reset during a read response with a write pending.
    clear_reqs();
    set_req(2, 1'b0, 8'h05, '0);
    step("pre_rst", 4'b0100, 4'b0100, 16'h1234);
    clear_reqs();
    set_req(1, 1'b1, 8'h50, 16'hDEAD);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst/rsp_v", 32'(bus.rsp_valid),        32'h0);
    chk("mid_rst/rsp_d", 32'(bus.rsp_data),         32'h0);
    chk("mid_rst/we",    32'(bus.mem_write_enable), 32'h0);
    chk("mid_rst/ready", 32'(bus.req_ready),        32'h0);
    #1;
    rst_n = 1'b1;
    clear_reqs();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, AW'(8'h40 + i), '0);
    step("after_rst0", 4'b0001, 4'b0001, ref_mem[8'h40]);
    step("after_rst1", 4'b0010, 4'b0010, ref_mem[8'h41]);
    chk("no_wr_in_rst", 32'(mem[8'h50]), 32'(ref_mem[8'h50]));

    clear_reqs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one simple dual-port Memory instance (async read port, sync write port) between NUM_REQ requesters, e.g. weight loader, activation writer and host DMA.
- Independent round-robin arbitration for the read port and the write port, so one read and one write can be serviced per cycle.
- Read data is registered and returned one cycle after the grant.
- Sits between the accelerator's client engines and each on-chip buffer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8, need not be a power of two).
- DEPTH, 8, memory address width in bits (memory holds 2**DEPTH words).
- BIT_SIZE, 16, data word width in bits.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_write  in  NUM_REQ  per-requester op: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*DEPTH  packed addresses; requester i uses bits [i*DEPTH +: DEPTH].
- req_wdata  in  NUM_REQ*BIT_SIZE  packed write data; requester i uses [i*BIT_SIZE +: BIT_SIZE].
- req_ready  out  NUM_REQ  grant; a transfer occurs when valid & ready.
- rsp_valid  out  NUM_REQ  one-hot read-response strobe.
- rsp_data  out  BIT_SIZE  registered read data, shared by all requesters.
- mem_write_enable  out  1  to Memory write_enable.
- mem_write_addr  out  DEPTH  to Memory write_addr.
- mem_data_in  out  BIT_SIZE  to Memory data_in.
- mem_read_addr  out  DEPTH  to Memory read_addr.
- mem_data_out  in  BIT_SIZE  from Memory data_out (combinational).

Behaviour:
- Clock and reset: one clock (clk); reset (rst_n) is asynchronous and active-low.
- Reset values: rd_ptr=0, wr_ptr=0, rsp_valid=0, rsp_data=0.
- While rst_n=0, req_ready=0 and mem_write_enable=0 (combinational gating), so no write reaches memory during reset.
- Request classes: read candidates = req_valid & ~req_write; write candidates = req_valid & req_write.
- Each requester presents at most one op per cycle, so it can win at most one arbiter.
- Arbitration: two independent round-robin arbiters, combinational within the cycle.
  - Each arbiter searches from its pointer upward, wrapping at NUM_REQ-1 to 0.
  - The first candidate found wins.
  - req_ready[i] = read_grant[i] | write_grant[i].
- Pointer update on posedge: if the arbiter granted requester g, ptr <= (g+1) mod NUM_REQ, explicit compare-and-wrap (no power-of-two masking). No grant: ptr holds.
- Write path, granted requester g:
  - mem_write_enable=1, mem_write_addr=req_addr[g], mem_data_in=req_wdata[g] in the same cycle.
  - Data is in memory after that posedge.
  - No write grant: mem_write_enable=0; mem_write_addr and mem_data_in are don't-care but driven to 0.
- Read path, granted requester g:
  - mem_read_addr=req_addr[g] in the same cycle.
  - At posedge: rsp_data <= mem_data_out, rsp_valid <= onehot(g).
  - Latency exactly 1 cycle; rsp_valid is high for exactly one cycle per granted read.
  - No read grant: rsp_valid <= 0, rsp_data holds its last value; mem_read_addr is driven to 0.
- Throughput: up to 1 read + 1 write per cycle. Back-to-back reads from one requester are allowed only when it is the sole read candidate.
- No response backpressure: requesters must accept rsp_valid unconditionally.
- Same-cycle read and write to the same address: the read returns the OLD data (async read precedes the write edge). A read granted in the cycle after the write returns the NEW data.
- Request hold: requesters hold valid, write, addr and wdata stable until ready. The arbiter keeps no request state, so a request dropped before ready is simply never serviced.
- Reset mid-operation: an in-flight read response is discarded (rsp_valid forced 0); pointers return to 0.

Decomposition:
- Package mem_arb_pkg:
  - localparams REQ_IDX_W = $clog2(NUM_REQ) (minimum 1) and the default NUM_REQ, DEPTH, BIT_SIZE.
  - Function onehot_to_idx.
  - Function next_ptr, mod-NUM_REQ increment.
- Sub-module rr_arbiter (params N; ports clk, rst_n, req[N], grant[N] one-hot, grant_idx, grant_valid).
  - Owns its pointer register.
  - Instantiated twice: read arbiter and write arbiter.
- Top level does operand muxing, response register and reset gating.

Test Plan:
- Single read: memory preloaded with addr 0x05=0x1234; req0 read addr 0x05 → req_ready[0]=1 same cycle; next cycle rsp_valid=4'b0001, rsp_data=0x1234.
- Write then read: req2 writes 0xBEEF to 0x10 at cycle t; req2 reads 0x10 at t+1 → rsp_data=0xBEEF at t+2.
- Round-robin fairness: all 4 requesters read continuously from reset → grants 0,1,2,3,0,… one per cycle. With NUM_REQ=3 → grants 0,1,2,0 (wrap without power of two).
- Concurrent ports and collision: req1 writes 0xAAAA to 0x20 while req3 reads 0x20 (old value 0x5555), same cycle → both ready; rsp_valid[3] next cycle with rsp_data=0x5555. A read the following cycle returns 0xAAAA.
- Idle pointer hold: rd_ptr=2 after granting req1, then 3 idle cycles, then req0 and req2 read → req2 granted first.
- Reset mid-op: assert rst_n=0 in the response cycle of a read, asynchronously → rsp_valid=0 immediately; mem_write_enable=0 despite a pending write request; after release, grants restart from requester 0.
